playback_ctrl: RTL



---
 rtl/playback_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/playback_ctrl.sv
// Playback control for the MP3 player: song index, VS1003 volume word, pause level
// and restart strobe. Every song change is wrapped in a click-free fade-out/fade-in.
module playback_ctrl #(
  parameter int         NUM_SONGS   = 4,
  parameter int         SEL_W       = 3,
  parameter logic [7:0] VOL_INIT    = 8'h20,
  parameter logic [7:0] VOL_MIN_ATT = 8'h00,
  parameter logic [7:0] VOL_MAX_ATT = 8'hC0,
  parameter logic [7:0] VOL_STEP    = 8'h08,
  parameter int         FADE_DIV    = 1000,
  parameter logic [7:0] FADE_STEP   = 8'h10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_next,
  input  logic             i_pre,
  input  logic             i_vol_plus,
  input  logic             i_vol_dec,
  input  logic             i_pause,
  input  logic             i_song_end,
  input  logic [1:0]       i_mode,
  output logic [SEL_W-1:0] o_song_select,
  output logic [15:0]      o_vol,
  output logic             o_pause,
  output logic             o_restart,
  output logic             o_busy
);

  localparam int               CNT_W      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [7:0]       ATT_SILENT = 8'hFE;
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_SONGS - 1);

  typedef enum logic [1:0] {PLAY, FADE_OUT, SWITCH, FADE_IN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       user_att_q, user_att_d;
  logic [7:0]       cur_att_q, cur_att_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pause_q, pause_d;
  logic             restart_q, restart_d;
  logic             busy_q, busy_d;

  logic             navNext, navPrev, navReq, endReq, tick;
  logic [SEL_W-1:0] navFromSel, navFromPend, shufIdx, endIdx;
  logic [8:0]       volUp9, volDn9, fadeUp9, fadeDn9;

  function automatic logic [SEL_W-1:0] incIdx(input logic [SEL_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
  endfunction

  function automatic logic [SEL_W-1:0] decIdx(input logic [SEL_W-1:0] idx);
    return (idx == '0) ? LAST_IDX : idx - SEL_W'(1);
  endfunction

  // Request decoding and 9-bit arithmetic so saturation never sees a wrapped value.
  always_comb begin
    navNext     = i_next & ~i_pre;
    navPrev     = i_pre & ~i_next;
    navReq      = navNext | navPrev;
    endReq      = i_song_end & ~i_next & ~i_pre;
    navFromSel  = navNext ? incIdx(sel_q) : decIdx(sel_q);
    navFromPend = navNext ? incIdx(pend_q) : decIdx(pend_q);
    shufIdx     = SEL_W'(lfsr_q % 16'(NUM_SONGS));
    case (i_mode)
      2'd1:    endIdx = sel_q;
      2'd2:    endIdx = (shufIdx == sel_q) ? incIdx(sel_q) : shufIdx;
      default: endIdx = incIdx(sel_q);
    endcase
    tick    = (cnt_q == CNT_W'(FADE_DIV - 1));
    volUp9  = {1'b0, user_att_q} - {1'b0, VOL_STEP};
    volDn9  = {1'b0, user_att_q} + {1'b0, VOL_STEP};
    fadeUp9 = {1'b0, cur_att_q} + {1'b0, FADE_STEP};
    fadeDn9 = {1'b0, cur_att_q} - {1'b0, FADE_STEP};
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_comb begin
    user_att_d = user_att_q;
    if (i_vol_plus && !i_vol_dec)
      user_att_d = (volUp9[8] || (volUp9[7:0] < VOL_MIN_ATT)) ? VOL_MIN_ATT : volUp9[7:0];
    else if (i_vol_dec && !i_vol_plus)
      user_att_d = (volDn9 > {1'b0, VOL_MAX_ATT}) ? VOL_MAX_ATT : volDn9[7:0];

    state_d   = state_q;
    cur_att_d = cur_att_q;
    sel_d     = sel_q;
    pend_d    = pend_q;
    restart_d = 1'b0;
    pause_d   = i_pause ? ~pause_q : pause_q;

    case (state_q)
      PLAY: begin
        cur_att_d = user_att_q;
        if (navReq) begin
          pend_d  = navFromSel;
          state_d = FADE_OUT;
        end else if (endReq) begin
          // Stop-at-end parks the driver in pause instead of changing song.
          if (i_mode == 2'd3) begin
            pause_d = 1'b1;
          end else begin
            pend_d  = endIdx;
            state_d = FADE_OUT;
          end
        end
      end
      FADE_OUT: begin
        if (navReq)
          pend_d = navFromPend;
        if (tick) begin
          if (cur_att_q == ATT_SILENT)
            state_d = SWITCH;
          else
            cur_att_d = (fadeUp9 > {1'b0, ATT_SILENT}) ? ATT_SILENT : fadeUp9[7:0];
        end
      end
      SWITCH: begin
        sel_d     = pend_q;
        restart_d = 1'b1;
        state_d   = FADE_IN;
      end
      FADE_IN: begin
        if (navReq) begin
          pend_d  = navFromSel;
          state_d = FADE_OUT;
        end else if (cur_att_q == user_att_q) begin
          state_d = PLAY;
        end else if (tick) begin
          cur_att_d = (fadeDn9[8] || (fadeDn9[7:0] < user_att_q)) ? user_att_q : fadeDn9[7:0];
        end
      end
      default: state_d = PLAY;
    endcase

    // The fade divider restarts whenever a fade state is (re)entered.
    if ((state_d != state_q) || ((state_d != FADE_OUT) && (state_d != FADE_IN)))
      cnt_d = '0;
    else if (tick)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CNT_W'(1);

    busy_d = (state_d != PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PLAY;
      user_att_q <= VOL_INIT;
      cur_att_q  <= VOL_INIT;
      sel_q      <= '0;
      pend_q     <= '0;
      lfsr_q     <= 16'hACE1;
      cnt_q      <= '0;
      pause_q    <= 1'b0;
      restart_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      user_att_q <= user_att_d;
      cur_att_q  <= cur_att_d;
      sel_q      <= sel_d;
      pend_q     <= pend_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      pause_q    <= pause_d;
      restart_q  <= restart_d;
      busy_q     <= busy_d;
    end
  end

  assign o_song_select = sel_q;
  assign o_vol         = {cur_att_q, cur_att_q};
  assign o_pause       = pause_q;
  assign o_restart     = restart_q;
  assign o_busy        = busy_q;

endmodule
